// File: rtl/lc2k_pkg.sv
// Shared definitions for the LC2K fetch unit: opcode values, the fetch
// FSM state encoding and the instruction field layout.
package lc2k_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    localparam int FIELD_W    = 3;
    localparam int OPCODE_LSB = 22;
    localparam int REG_A_LSB  = 19;
    localparam int REG_B_LSB  = 16;
    localparam int DEST_LSB   = 0;
    localparam int OFFSET_LSB = 0;
    localparam int OFFSET_W   = 16;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALTED  = 2'd3
    } state_t;

endpackage

// File: rtl/lc2k_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus. The fetch unit is the master,
// the memory (or its model) is the slave.
interface lc2k_fetch_unit_if;
    import lc2k_pkg::*;

    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ack;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/lc2k_decoder.sv
// Purely combinational field extraction for an LC2K instruction word,
// including sign extension of the 16-bit offset.
module lc2k_decoder
    import lc2k_pkg::*;
(
    input  logic [WORD_W-1:0]  instruction,
    output logic [FIELD_W-1:0] opcode,
    output logic [FIELD_W-1:0] reg_a,
    output logic [FIELD_W-1:0] reg_b,
    output logic [FIELD_W-1:0] dest,
    output logic [WORD_W-1:0]  offset_ext
);

    // Bits above the opcode carry no meaning in LC2K.
    logic unused_high_bits;
    assign unused_high_bits = ^instruction[WORD_W-1:OPCODE_LSB+FIELD_W];

    // Slice fields and replicate the offset sign bit into the upper half.
    always_comb begin
        opcode     = instruction[OPCODE_LSB +: FIELD_W];
        reg_a      = instruction[REG_A_LSB  +: FIELD_W];
        reg_b      = instruction[REG_B_LSB  +: FIELD_W];
        dest       = instruction[DEST_LSB   +: FIELD_W];
        offset_ext = {{(WORD_W-OFFSET_W){instruction[OFFSET_LSB+OFFSET_W-1]}},
                      instruction[OFFSET_LSB +: OFFSET_W]};
    end

endmodule

// File: rtl/lc2k_fetch_unit.sv
// LC2K fetch unit: runs the FETCH/DECODE/EXECUTE/HALTED sequence, owns the
// program counter and the retired-instruction counter, and presents the
// decoded fields of the latched instruction to the datapath.
module lc2k_fetch_unit
    import lc2k_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [2:0]  opcode,
    output logic [2:0]  reg_a,
    output logic [2:0]  reg_b,
    output logic [2:0]  dest,
    output logic [31:0] offset_ext,
    output logic [31:0] pc_current,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] instr_count
);

    state_t      state;
    logic [31:0] next_pc;

    lc2k_decoder u_decoder (
        .instruction (instruction),
        .opcode      (opcode),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .dest        (dest),
        .offset_ext  (offset_ext)
    );

    // The request is gated by rst_n so it is low throughout reset and rises
    // in the very first cycle after release.
    assign imem_req  = rst_n & (state == FETCH);
    assign imem_addr = pc_current;

    // Next-PC selection: halt wins over jalr, which wins over a taken branch.
    always_comb begin
        next_pc = pc_current + 32'd1;
        if (halt) begin
            next_pc = pc_current + 32'd1;
        end else if (jalr) begin
            next_pc = jalr_target;
        end else if (branch_taken) begin
            next_pc = pc_current + 32'd1 + offset_ext;
        end
        next_pc = next_pc & ADDR_MASK;
    end

    // Fetch FSM with registered status flags, PC and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc_current  <= RESET_PC;
            instruction <= 32'h0;
            instr_count <= 32'h0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    instr_valid <= 1'b0;
                    state       <= EXECUTE;
                end
                EXECUTE: begin
                    if (exec_done) begin
                        pc_current <= next_pc;
                        if (instr_count != 32'hFFFF_FFFF) begin
                            instr_count <= instr_count + 32'd1;
                        end
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            state  <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc2k_fetch_unit.sv
// Self-checking bench for lc2k_fetch_unit: a table of instructions walked
// through fetch/decode/execute with decode results scoreboarded, followed by
// hand-written sequences for ignored strobes, halt and mid-execute reset.
module tb_lc2k_fetch_unit;
    import lc2k_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic [2:0]  opcode, reg_a, reg_b, dest;
    logic [31:0] offset_ext, pc_current, instr_count, jalr_target;
    logic        instr_valid, exec_done, branch_taken, jalr, halt, halted;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lc2k_fetch_unit_if bus ();

    lc2k_fetch_unit #(.RESET_PC(32'h0), .ADDR_MASK(32'h0000FFFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (bus.req),
        .imem_addr    (bus.addr),
        .imem_ack     (bus.ack),
        .imem_rdata   (bus.rdata),
        .instruction  (instruction),
        .opcode       (opcode),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .dest         (dest),
        .offset_ext   (offset_ext),
        .pc_current   (pc_current),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .jalr         (jalr),
        .jalr_target  (jalr_target),
        .halt         (halt),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    typedef struct {
        logic [31:0] word;
        logic [2:0]  op, a, b, d;
        logic [31:0] off;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        int          ack_dly;
        int          done_dly;
        logic        br, jl, hl;
        logic [31:0] tgt;
        logic [2:0]  op, a, b, d;
        logic [31:0] off;
        logic [31:0] next_pc;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];
    logic [31:0] exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every instr_valid pulse must match the oldest pending decode.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr_valid: got instruction %h expected no decode", instruction);
            end else begin
                mon_e = sb.pop_front();
                check("dec_instruction", instruction, mon_e.word);
                check("dec_opcode", 32'(opcode), 32'(mon_e.op));
                check("dec_reg_a", 32'(reg_a), 32'(mon_e.a));
                check("dec_reg_b", 32'(reg_b), 32'(mon_e.b));
                check("dec_dest", 32'(dest), 32'(mon_e.d));
                check("dec_offset_ext", offset_ext, mon_e.off);
                check("dec_pc_current", pc_current, mon_e.pc);
            end
        end
    end

    task automatic clear_exec();
        exec_done = 1'b0; branch_taken = 1'b0; jalr = 1'b0; halt = 1'b0;
        jalr_target = 32'h0;
    endtask

    // Called at a negedge; waits for FETCH, holds ack off ack_dly cycles.
    task automatic do_fetch(input exp_t e, input int ack_dly);
        int n;
        int held;
        n = 0;
        held = 0;
        while (bus.req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req_seen", 32'(bus.req), 32'd1);
        check("fetch_addr", bus.addr, e.pc);
        for (int i = 0; i < ack_dly; i++) begin
            if (bus.req === 1'b1) held++;
            @(negedge clk);
        end
        if (bus.req === 1'b1) held++;
        bus.rdata = e.word;
        bus.ack = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.ack = 1'b0;
        bus.rdata = 32'hDEAD_BEEF;
        check("fetch_req_held_cycles", 32'(held), 32'(ack_dly + 1));
        check("decode_req_low", 32'(bus.req), 32'd0);
    endtask

    // Called at the DECODE negedge; finishes with exec_done sampled once.
    task automatic do_exec(input logic br, input logic jl, input logic hl,
                           input logic [31:0] tgt, input int done_dly);
        @(negedge clk);
        check("exec_instr_valid_low", 32'(instr_valid), 32'd0);
        for (int i = 0; i < done_dly; i++) @(negedge clk);
        exec_done = 1'b1; branch_taken = br; jalr = jl; halt = hl; jalr_target = tgt;
        @(negedge clk);
        clear_exec();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_req, bad_halted, bad_pc, bad_cnt;
        exp_t e;

        //          word          ackd dnd br   jl   hl   tgt            op       a     b     d     off            next_pc
        vecs[0] = '{32'h000A0003, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        OP_ADD,  3'd1, 3'd2, 3'd3, 32'h00000003, 32'h1};
        vecs[1] = '{32'h0081FFFF, 4, 0, 1'b0, 1'b0, 1'b0, 32'h0,        OP_LW,   3'd0, 3'd1, 3'd7, 32'hFFFFFFFF, 32'h2};
        vecs[2] = '{32'h014A0000, 0, 2, 1'b0, 1'b1, 1'b0, 32'h5,        OP_JALR, 3'd1, 3'd2, 3'd0, 32'h00000000, 32'h5};
        vecs[3] = '{32'h0100FFFD, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0,        OP_BEQ,  3'd0, 3'd0, 3'd5, 32'hFFFFFFFD, 32'h3};
        vecs[4] = '{32'h014A0000, 0, 0, 1'b0, 1'b1, 1'b0, 32'h5,        OP_JALR, 3'd1, 3'd2, 3'd0, 32'h00000000, 32'h5};
        vecs[5] = '{32'h0100FFFD, 0, 1, 1'b1, 1'b1, 1'b0, 32'd20,       OP_BEQ,  3'd0, 3'd0, 3'd5, 32'hFFFFFFFD, 32'd20};
        vecs[6] = '{32'h005C0001, 2, 0, 1'b0, 1'b1, 1'b0, 32'h1234FFFF, OP_NOR,  3'd3, 3'd4, 3'd1, 32'h00000001, 32'hFFFF};
        vecs[7] = '{32'h01C00000, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0,        OP_NOOP, 3'd0, 3'd0, 3'd0, 32'h00000000, 32'h0};
        vecs[8] = '{32'h01007FFF, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        OP_BEQ,  3'd0, 3'd0, 3'd7, 32'h00007FFF, 32'h1};
        vecs[9] = '{32'h0100FFFB, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0,        OP_BEQ,  3'd0, 3'd0, 3'd3, 32'hFFFFFFFB, 32'hFFFD};

        rst_n = 1'b0;
        bus.ack = 1'b0;
        bus.rdata = 32'h0;
        clear_exec();
        repeat (3) @(negedge clk);
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_pc", pc_current, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_count", instr_count, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_req", 32'(bus.req), 32'd1);
        @(negedge clk);

        exp_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            e = '{vecs[i].word, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].off, exp_pc};
            do_fetch(e, vecs[i].ack_dly);
            do_exec(vecs[i].br, vecs[i].jl, vecs[i].hl, vecs[i].tgt, vecs[i].done_dly);
            check("row_next_pc", pc_current, vecs[i].next_pc);
            check("row_next_addr", bus.addr, vecs[i].next_pc);
            check("row_count", instr_count, 32'(i + 1));
            exp_pc = vecs[i].next_pc;
        end

        // exec_done during FETCH must not retire or redirect.
        exec_done = 1'b1; branch_taken = 1'b1; jalr = 1'b1; jalr_target = 32'h77;
        repeat (3) @(negedge clk);
        clear_exec();
        check("fetch_done_ignored_pc", pc_current, 32'hFFFD);
        check("fetch_done_ignored_count", instr_count, 32'd10);
        check("fetch_done_req_held", 32'(bus.req), 32'd1);

        // ack during EXECUTE must not relatch or re-decode.
        e = '{32'h00CA0007, OP_SW, 3'd1, 3'd2, 3'd7, 32'h00000007, 32'hFFFD};
        do_fetch(e, 0);
        @(negedge clk);
        bus.ack = 1'b1;
        bus.rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        bus.ack = 1'b0;
        check("exec_ack_ignored_instr", instruction, 32'h00CA0007);
        exec_done = 1'b1;
        @(negedge clk);
        clear_exec();
        check("after_sw_pc", pc_current, 32'hFFFE);
        check("after_sw_count", instr_count, 32'd11);

        // halt beats jalr; unit then stays stopped.
        e = '{32'h01800000, OP_HALT, 3'd0, 3'd0, 3'd0, 32'h0, 32'hFFFE};
        do_fetch(e, 0);
        do_exec(1'b1, 1'b1, 1'b1, 32'h1234, 0);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc", pc_current, 32'hFFFF);
        check("halt_count", instr_count, 32'd12);
        bad_req = 0; bad_halted = 0; bad_pc = 0; bad_cnt = 0;
        bus.ack = 1'b1;
        bus.rdata = 32'h000A0003;
        exec_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req !== 1'b0) bad_req++;
            if (halted !== 1'b1) bad_halted++;
            if (pc_current !== 32'hFFFF) bad_pc++;
            if (instr_count !== 32'd12) bad_cnt++;
        end
        bus.ack = 1'b0;
        clear_exec();
        check("halted_req_bad_cycles", 32'(bad_req), 32'd0);
        check("halted_flag_bad_cycles", 32'(bad_halted), 32'd0);
        check("halted_pc_bad_cycles", 32'(bad_pc), 32'd0);
        check("halted_count_bad_cycles", 32'(bad_cnt), 32'd0);

        // Reset leaves HALTED; then reset in the middle of EXECUTE.
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_pc", pc_current, 32'h0);
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_count", instr_count, 32'd0);
        rst_n = 1'b1;
        e = '{32'h000A0003, OP_ADD, 3'd1, 3'd2, 3'd3, 32'h3, 32'h0};
        do_fetch(e, 0);
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);
        check("restart_pc", pc_current, 32'h1);
        check("restart_count", instr_count, 32'd1);
        e = '{32'h0081FFFF, OP_LW, 3'd0, 3'd1, 3'd7, 32'hFFFFFFFF, 32'h1};
        do_fetch(e, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_exec_rst_pc", pc_current, 32'h0);
        check("mid_exec_rst_count", instr_count, 32'd0);
        check("mid_exec_rst_req", 32'(bus.req), 32'd0);
        check("mid_exec_rst_instruction", instruction, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_exec_release_req", 32'(bus.req), 32'd1);
        check("mid_exec_release_addr", bus.addr, 32'h0);
        @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
